// File: rtl/multicycle_ctrl.sv
// Main control FSM for the multicycle MIPS core: sequences fetch, decode, execute,
// memory and writeback, stalling fetch and load/store states on the memory-ready handshake.
module multicycle_ctrl #(
    parameter bit ILLEGAL_TRAP = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic       zero,
    input  logic       memrdy,
    output logic [1:0] aluop,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic       zeroext,
    output logic [1:0] pcsrc,
    output logic       pcen,
    output logic       iord,
    output logic       memwrite,
    output logic       irwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       regwrite,
    output logic       illegal,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        StFetch   = 4'd0,
        StDecode  = 4'd1,
        StMemAdr  = 4'd2,
        StMemRd   = 4'd3,
        StMemWb   = 4'd4,
        StMemWr   = 4'd5,
        StRtypeEx = 4'd6,
        StRtypeWb = 4'd7,
        StBeqEx   = 4'd8,
        StAddiEx  = 4'd9,
        StOriEx   = 4'd10,
        StImmWb   = 4'd11,
        StJEx     = 4'd12,
        StHalt    = 4'd13
    } state_e;

    localparam logic [5:0] OpLw   = 6'b100011;
    localparam logic [5:0] OpSw   = 6'b101011;
    localparam logic [5:0] OpR    = 6'b000000;
    localparam logic [5:0] OpBeq  = 6'b000100;
    localparam logic [5:0] OpAddi = 6'b001000;
    localparam logic [5:0] OpOri  = 6'b001101;
    localparam logic [5:0] OpJ    = 6'b000010;

    state_e r_state;
    state_e w_state_next;
    logic   w_memrdy;
    logic   w_pcwrite;
    logic   w_branch;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= StFetch;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Handshake is masked during reset so no strobe can fire while reset is held.
    assign w_memrdy = memrdy & reset;

    always_comb begin
        w_state_next = r_state;
        aluop        = 2'b00;
        alusrca      = 1'b0;
        alusrcb      = 2'b00;
        zeroext      = 1'b0;
        pcsrc        = 2'b00;
        iord         = 1'b0;
        memwrite     = 1'b0;
        irwrite      = 1'b0;
        regdst       = 1'b0;
        memtoreg     = 1'b0;
        regwrite     = 1'b0;
        illegal      = 1'b0;
        w_pcwrite    = 1'b0;
        w_branch     = 1'b0;

        unique case (r_state)
            StFetch: begin
                alusrcb      = 2'b01;
                irwrite      = w_memrdy;
                w_pcwrite    = w_memrdy;
                w_state_next = w_memrdy ? StDecode : StFetch;
            end
            StDecode: begin
                alusrcb = 2'b11;
                case (op)
                    OpLw, OpSw: w_state_next = StMemAdr;
                    OpR:        w_state_next = StRtypeEx;
                    OpBeq:      w_state_next = StBeqEx;
                    OpAddi:     w_state_next = StAddiEx;
                    OpOri:      w_state_next = StOriEx;
                    OpJ:        w_state_next = StJEx;
                    default: begin
                        illegal      = 1'b1;
                        w_state_next = ILLEGAL_TRAP ? StHalt : StFetch;
                    end
                endcase
            end
            StMemAdr: begin
                alusrca      = 1'b1;
                alusrcb      = 2'b10;
                w_state_next = (op == OpSw) ? StMemWr : StMemRd;
            end
            StMemRd: begin
                iord         = 1'b1;
                w_state_next = w_memrdy ? StMemWb : StMemRd;
            end
            StMemWb: begin
                memtoreg     = 1'b1;
                regwrite     = 1'b1;
                w_state_next = StFetch;
            end
            StMemWr: begin
                iord         = 1'b1;
                memwrite     = w_memrdy;
                w_state_next = w_memrdy ? StFetch : StMemWr;
            end
            StRtypeEx: begin
                alusrca      = 1'b1;
                aluop        = 2'b10;
                w_state_next = StRtypeWb;
            end
            StRtypeWb: begin
                regdst       = 1'b1;
                regwrite     = 1'b1;
                w_state_next = StFetch;
            end
            StBeqEx: begin
                alusrca      = 1'b1;
                aluop        = 2'b01;
                pcsrc        = 2'b01;
                w_branch     = 1'b1;
                w_state_next = StFetch;
            end
            StAddiEx: begin
                alusrca      = 1'b1;
                alusrcb      = 2'b10;
                w_state_next = StImmWb;
            end
            StOriEx: begin
                alusrca      = 1'b1;
                alusrcb      = 2'b10;
                zeroext      = 1'b1;
                aluop        = 2'b11;
                w_state_next = StImmWb;
            end
            StImmWb: begin
                regwrite     = 1'b1;
                w_state_next = StFetch;
            end
            StJEx: begin
                pcsrc        = 2'b10;
                w_pcwrite    = 1'b1;
                w_state_next = StFetch;
            end
            StHalt: begin
                w_state_next = StHalt;
            end
            default: begin
                w_state_next = StFetch;
            end
        endcase
    end

    assign pcen  = w_pcwrite | (w_branch & zero);
    assign state = r_state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: two instances (no trap / trap) share stimulus and are
// checked cycle by cycle against hand-computed state sequences and strobe values.
module tb_multicycle_ctrl;

    localparam logic [5:0] OpR   = 6'b000000;
    localparam logic [5:0] OpLw  = 6'b100011;
    localparam logic [5:0] OpSw  = 6'b101011;
    localparam logic [5:0] OpBeq = 6'b000100;
    localparam logic [5:0] OpAdd = 6'b001000;
    localparam logic [5:0] OpOri = 6'b001101;
    localparam logic [5:0] OpJ   = 6'b000010;
    localparam logic [5:0] OpIll = 6'b111111;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] op;
    logic       zero;
    logic       memrdy;

    logic [1:0] aluop0, alusrcb0, pcsrc0, aluop1, alusrcb1, pcsrc1;
    logic       alusrca0, zeroext0, pcen0, iord0, mw0, irw0, regdst0, memtoreg0, rw0, il0;
    logic       alusrca1, zeroext1, pcen1, iord1, mw1, irw1, regdst1, memtoreg1, rw1, il1;
    logic [3:0] s0, s1;

    int n_vec = 0;
    int n_err = 0;
    int n_irw, n_mw, n_rw;
    logic halted = 1'b0;

    always #5 clk = ~clk;

    multicycle_ctrl #(.ILLEGAL_TRAP(1'b0)) dut0 (
        .clk(clk), .reset(reset), .op(op), .zero(zero), .memrdy(memrdy),
        .aluop(aluop0), .alusrca(alusrca0), .alusrcb(alusrcb0), .zeroext(zeroext0),
        .pcsrc(pcsrc0), .pcen(pcen0), .iord(iord0), .memwrite(mw0), .irwrite(irw0),
        .regdst(regdst0), .memtoreg(memtoreg0), .regwrite(rw0), .illegal(il0), .state(s0)
    );

    multicycle_ctrl #(.ILLEGAL_TRAP(1'b1)) dut1 (
        .clk(clk), .reset(reset), .op(op), .zero(zero), .memrdy(memrdy),
        .aluop(aluop1), .alusrca(alusrca1), .alusrcb(alusrcb1), .zeroext(zeroext1),
        .pcsrc(pcsrc1), .pcen(pcen1), .iord(iord1), .memwrite(mw1), .irwrite(irw1),
        .regdst(regdst1), .memtoreg(memtoreg1), .regwrite(rw1), .illegal(il1), .state(s1)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Drive inputs just after the edge, then sample at the falling edge.
    task automatic cyc(input logic [5:0] o, input logic m, input logic [3:0] exp_st);
        @(posedge clk);
        #1;
        op     = o;
        memrdy = m;
        @(negedge clk);
        check_eq("state", 32'(s0), 32'(exp_st));
        check_eq("trap_state", 32'(s1), halted ? 32'd13 : 32'(exp_st));
        if (halted) check_eq("halt_strobes", 32'({rw1, mw1, irw1, pcen1, il1}), 32'd0);
        check_eq("one_write", 32'($countones({rw0, mw0, irw0}) <= 1), 32'd1);
        if (!(exp_st inside {4'd0, 4'd8, 4'd12})) check_eq("pcen_outside", 32'(pcen0), 32'd0);
        n_irw += int'(irw0);
        n_mw  += int'(mw0);
        n_rw  += int'(rw0);
    endtask

    task automatic clr_cnt();
        n_irw = 0;
        n_mw  = 0;
        n_rw  = 0;
    endtask

    initial begin
        reset  = 1'b0;
        op     = OpR;
        zero   = 1'b0;
        memrdy = 1'b1;
        clr_cnt();

        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            @(negedge clk);
            check_eq("rst_state", 32'(s0), 32'd0);
            check_eq("rst_strobes", 32'({irw0, pcen0, mw0, rw0, il0}), 32'd0);
            check_eq("rst_alusrcb", 32'(alusrcb0), 32'b01);
            check_eq("rst_aluop", 32'(aluop0), 32'b00);
        end

        // R-type: 0,1,6,7
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        check_eq("r_fetch_state", 32'(s0), 32'd0);
        check_eq("r_fetch_irw_pcen", 32'({irw0, pcen0}), 32'b11);
        cyc(OpR, 1'b1, 4'd1);
        check_eq("r_dec_irw_pcen", 32'({irw0, pcen0}), 32'b00);
        check_eq("r_dec_alusrcb", 32'(alusrcb0), 32'b11);
        cyc(OpR, 1'b1, 4'd6);
        check_eq("r_ex_aluop", 32'(aluop0), 32'b10);
        check_eq("r_ex_srcs", 32'({alusrca0, alusrcb0}), 32'b100);
        cyc(OpR, 1'b1, 4'd7);
        check_eq("r_wb", 32'({regdst0, rw0, irw0, pcen0}), 32'b1100);

        // lw with stalls: 0,0,0,1,2,3,3,3,3,4
        clr_cnt();
        cyc(OpLw, 1'b0, 4'd0);
        check_eq("lw_stall_irw", 32'(irw0), 32'd0);
        cyc(OpLw, 1'b0, 4'd0);
        cyc(OpLw, 1'b1, 4'd0);
        cyc(OpLw, 1'b1, 4'd1);
        cyc(OpLw, 1'b1, 4'd2);
        check_eq("lw_adr_srcs", 32'({alusrca0, alusrcb0}), 32'b110);
        cyc(OpLw, 1'b0, 4'd3);
        check_eq("lw_rd_iord", 32'(iord0), 32'd1);
        cyc(OpLw, 1'b0, 4'd3);
        cyc(OpLw, 1'b0, 4'd3);
        cyc(OpLw, 1'b1, 4'd3);
        cyc(OpLw, 1'b1, 4'd4);
        check_eq("lw_wb", 32'({memtoreg0, rw0, regdst0}), 32'b110);
        check_eq("lw_irw_count", 32'(n_irw), 32'd1);

        // sw with one stall in MEMWR
        clr_cnt();
        cyc(OpSw, 1'b1, 4'd0);
        cyc(OpSw, 1'b1, 4'd1);
        cyc(OpSw, 1'b1, 4'd2);
        cyc(OpSw, 1'b0, 4'd5);
        check_eq("sw_stall", 32'({iord0, mw0}), 32'b10);
        cyc(OpSw, 1'b1, 4'd5);
        check_eq("sw_write", 32'({iord0, mw0}), 32'b11);
        check_eq("sw_mw_count", 32'(n_mw), 32'd1);
        check_eq("sw_rw_count", 32'(n_rw), 32'd0);

        // beq taken, then not taken
        zero = 1'b1;
        cyc(OpBeq, 1'b1, 4'd0);
        cyc(OpBeq, 1'b1, 4'd1);
        cyc(OpBeq, 1'b1, 4'd8);
        check_eq("beq_t_pcen", 32'(pcen0), 32'd1);
        check_eq("beq_t_pcsrc", 32'(pcsrc0), 32'b01);
        check_eq("beq_aluop", 32'(aluop0), 32'b01);
        zero = 1'b0;
        cyc(OpBeq, 1'b1, 4'd0);
        cyc(OpBeq, 1'b1, 4'd1);
        cyc(OpBeq, 1'b1, 4'd8);
        check_eq("beq_nt_pcen", 32'(pcen0), 32'd0);

        // ori, addi, j
        cyc(OpOri, 1'b1, 4'd0);
        cyc(OpOri, 1'b1, 4'd1);
        cyc(OpOri, 1'b1, 4'd10);
        check_eq("ori_ex", 32'({aluop0, zeroext0, alusrcb0}), 32'b11110);
        cyc(OpOri, 1'b1, 4'd11);
        check_eq("ori_wb", 32'({rw0, regdst0, memtoreg0}), 32'b100);
        cyc(OpAdd, 1'b1, 4'd0);
        cyc(OpAdd, 1'b1, 4'd1);
        cyc(OpAdd, 1'b1, 4'd9);
        check_eq("addi_ex", 32'({aluop0, zeroext0, alusrcb0}), 32'b00010);
        cyc(OpAdd, 1'b1, 4'd11);
        cyc(OpJ, 1'b1, 4'd0);
        cyc(OpJ, 1'b1, 4'd1);
        cyc(OpJ, 1'b1, 4'd12);
        check_eq("j_ex", 32'({pcsrc0, pcen0}), 32'b101);

        // illegal opcode on both instances
        cyc(OpIll, 1'b1, 4'd0);
        check_eq("ill_fetch", 32'({il0, il1}), 32'b00);
        cyc(OpIll, 1'b1, 4'd1);
        check_eq("ill_pulse", 32'({il0, il1}), 32'b11);
        halted = 1'b1;
        cyc(OpIll, 1'b1, 4'd0);
        check_eq("ill_after", 32'(il0), 32'd0);
        cyc(OpR, 1'b1, 4'd1);
        cyc(OpR, 1'b1, 4'd6);

        // lw aborted by reset in MEMRD
        clr_cnt();
        cyc(OpLw, 1'b1, 4'd7);
        cyc(OpLw, 1'b1, 4'd0);
        cyc(OpLw, 1'b1, 4'd1);
        cyc(OpLw, 1'b1, 4'd2);
        cyc(OpLw, 1'b0, 4'd3);
        clr_cnt();
        #2;
        reset  = 1'b0;
        memrdy = 1'b1;
        #1;
        check_eq("abort_state", 32'(s0), 32'd0);
        check_eq("abort_trap_state", 32'(s1), 32'd0);
        check_eq("abort_strobes", 32'({rw0, irw0, pcen0, mw0}), 32'd0);
        halted = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            @(negedge clk);
            check_eq("abort_hold", 32'({s0, rw0, irw0}), 32'd0);
            n_rw += int'(rw0);
        end
        check_eq("abort_rw_count", 32'(n_rw), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        op    = OpJ;
        @(negedge clk);
        check_eq("post_fetch", 32'({s0, irw0}), 32'b00001);
        cyc(OpJ, 1'b1, 4'd1);
        cyc(OpJ, 1'b1, 4'd12);
        check_eq("post_j", 32'({pcsrc0, pcen0}), 32'b101);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Main control FSM for the multicycle build of the 32-bit MIPS core.
- Decodes the 6-bit opcode over several clock cycles and sequences the datapath: fetch, decode, execute, memory, writeback.
- Produces the 2-bit aluop consumed by the ALU decoder, which turns aluop plus funct into the 4-bit ALU control. Also produces all register-enable and mux-select strobes.
- Adds a memory-ready handshake so that fetch and load/store states stall on slow memory.

Parameters:
- ILLEGAL_TRAP, 0: 0 = an unknown opcode returns to FETCH after DECODE; 1 = an unknown opcode enters HALT until reset.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low reset (0 = reset asserted)
- op  input  6  instruction opcode, from the instruction register bits [31:26]
- zero  input  1  ALU zero flag
- memrdy  input  1  memory completes the current access this cycle
- aluop  output  2  to the ALU decoder: 00 add, 01 sub, 10 funct-decoded, 11 or
- alusrca  output  1  ALU A: 0 = PC, 1 = register A
- alusrcb  output  2  ALU B: 00 = register B, 01 = constant 4, 10 = immediate, 11 = immediate shifted left 2
- zeroext  output  1  immediate is zero-extended (ori) instead of sign-extended
- pcsrc  output  2  next PC: 00 = ALU result, 01 = ALUOut, 10 = jump target
- pcen  output  1  PC load enable = pcwrite_int OR (branch_int AND zero)
- iord  output  1  memory address: 0 = PC, 1 = ALUOut
- memwrite  output  1  memory write strobe
- irwrite  output  1  instruction register load
- regdst  output  1  write register: 0 = rt, 1 = rd
- memtoreg  output  1  register write data: 0 = ALUOut, 1 = memory data
- regwrite  output  1  register file write
- illegal  output  1  one-cycle pulse in DECODE when op is unsupported
- state  output  4  current state encoding, for debug

Behaviour:
- Single always block for the state register, clocked on posedge clk and sensitive to negedge reset. Next-state logic and outputs are combinational (Moore), except that pcen also depends on zero and the handshake strobes also depend on memrdy.
- While reset is 0: state = FETCH (0). All outputs derive from FETCH with memrdy forced to 0: every strobe is 0, aluop = 00, alusrcb = 01. Reset asserted mid-instruction aborts the instruction immediately; no further strobes are issued.
- Supported opcodes: lw 100011, sw 101011, R-type 000000, beq 000100, addi 001000, ori 001101, j 000010.
- States and transitions. Any output not listed is 0.
  - FETCH (0): iord=0, alusrcb=01, aluop=00, pcsrc=00. irwrite=memrdy, pcen=memrdy. Next state is DECODE if memrdy=1, else FETCH.
  - DECODE (1): alusrcb=11, aluop=00.
    - lw or sw -> MEMADR
    - R-type -> RTYPEEX
    - beq -> BEQEX
    - addi -> ADDIEX
    - ori -> ORIEX
    - j -> JEX
    - other opcode -> illegal=1, then HALT if ILLEGAL_TRAP=1, else FETCH
  - MEMADR (2): alusrca=1, alusrcb=10, aluop=00. Next state is MEMRD for lw, MEMWR for sw.
  - MEMRD (3): iord=1. Next state is MEMWB if memrdy=1, else MEMRD.
  - MEMWB (4): memtoreg=1, regwrite=1, regdst=0 -> FETCH.
  - MEMWR (5): iord=1, memwrite=memrdy. Next state is FETCH if memrdy=1, else MEMWR. memwrite pulses exactly once per sw.
  - RTYPEEX (6): alusrca=1, alusrcb=00, aluop=10 -> RTYPEWB.
  - RTYPEWB (7): regdst=1, regwrite=1 -> FETCH.
  - BEQEX (8): alusrca=1, alusrcb=00, aluop=01, pcsrc=01, branch_int=1, so pcen=zero -> FETCH.
  - ADDIEX (9): alusrca=1, alusrcb=10, aluop=00 -> IMMWB.
  - ORIEX (10): alusrca=1, alusrcb=10, zeroext=1, aluop=11 -> IMMWB.
  - IMMWB (11): regdst=0, memtoreg=0, regwrite=1 -> FETCH.
  - JEX (12): pcsrc=10, pcen=1 -> FETCH.
  - HALT (13): all strobes 0, aluop=00. Stays in HALT until reset.
  - Codes 14 and 15 are unreachable. If ever entered, next state = FETCH and all strobes = 0.
- Instruction latency in cycles, with no memory stall: lw 5, sw 4, R-type 4, addi/ori 4, beq 3, j 3. Each stall cycle adds 1.
- At most one of regwrite, memwrite, irwrite is 1 in any cycle.
- pcen is never 1 outside FETCH, BEQEX and JEX.
- op is sampled only in DECODE and MEMADR. Changes to op in any other state are ignored.

Test Plan:
- Hold reset=0 for 3 cycles, then release with memrdy=1 and op=000000 (R-type) -> state sequence 0,1,6,7,0. aluop=10 in state 6, regdst=1 and regwrite=1 in state 7. pcen=1 and irwrite=1 only in the FETCH cycles.
- lw (100011) with memrdy held 0 for 2 cycles in FETCH and 3 cycles in MEMRD -> sequence 0,0,0,1,2,3,3,3,3,4,0. irwrite pulses exactly once. memtoreg=1 and regwrite=1 in state 4.
- sw (101011) with memrdy=0 for 1 cycle in MEMWR -> exactly one memwrite pulse, with iord=1. Return to FETCH. regwrite stays 0 throughout.
- beq (000100), run twice: zero=1 -> pcen=1 and pcsrc=01 in BEQEX; zero=0 -> pcen=0. Both return to FETCH after 3 cycles.
- ori (001101), addi (001000) and j (000010) -> ori: aluop=11 and zeroext=1 in ORIEX. addi: aluop=00 and zeroext=0. j: pcsrc=10 and pcen=1 in JEX.
- Illegal op 111111, run with ILLEGAL_TRAP=0 and 1; also assert reset=0 mid-MEMRD -> illegal pulses in DECODE. TRAP=0 returns to FETCH; TRAP=1 sits in HALT (13) with all strobes 0. Mid-MEMRD reset forces state 0 asynchronously, with no regwrite issued.
